// File: rtl/reg_reader.sv
// Read-side sequencer: walks a register block from BASE up or down COUNT neighbours,
// drives the combinational register-file read index and accumulates the returned data.
module reg_reader #(
    parameter int WIDTH = 32,
    parameter int BASE  = 8,
    parameter int COUNT = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             direction,
    input  logic [WIDTH-1:0] rdata,
    output logic [4:0]       regnum,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             overflow
);

    // The block must fit entirely inside the 32-entry register file in either direction.
    generate
        if (BASE - COUNT < 0 || BASE + COUNT > 31 || COUNT < 0) begin : gBadLayout
            $error("reg_reader: block BASE=%0d COUNT=%0d does not fit in 32 registers", BASE, COUNT);
        end
    endgenerate

    localparam logic [4:0] BASE_IDX   = 5'(BASE);
    localparam logic [3:0] LAST_INDEX = 4'(COUNT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        READ  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t           stateReg;
    logic [3:0]       idxReg;
    logic             dirReg;
    logic [WIDTH-1:0] sumReg;
    logic             overflowReg;
    logic [4:0]       regnumReg;
    logic             busyReg;
    logic             doneReg;

    logic [WIDTH-1:0] addResult;
    logic             addCarry;
    logic [3:0]       idxNext;
    logic [4:0]       regnumStep;

    // Unsigned accumulate with the carry-out kept separate for the sticky overflow flag.
    always_comb begin
        {addCarry, addResult} = {1'b0, sumReg} + {1'b0, rdata};
    end

    // Index of the register to present on the cycle after this one.
    always_comb begin
        idxNext    = idxReg + 4'd1;
        regnumStep = dirReg ? (BASE_IDX + {1'b0, idxNext})
                            : (BASE_IDX - {1'b0, idxNext});
    end

    // Outputs are registered together with the state so they always match it (Moore).
    always_ff @(posedge clock) begin
        if (!reset) begin
            stateReg    <= IDLE;
            idxReg      <= 4'd0;
            dirReg      <= 1'b0;
            sumReg      <= '0;
            overflowReg <= 1'b0;
            regnumReg   <= 5'd0;
            busyReg     <= 1'b0;
            doneReg     <= 1'b0;
        end else begin
            case (stateReg)
                IDLE: begin
                    if (go) begin
                        stateReg  <= ARMED;
                        regnumReg <= BASE_IDX;
                    end
                end

                ARMED: begin
                    if (!go) begin
                        stateReg    <= READ;
                        dirReg      <= direction;
                        idxReg      <= 4'd0;
                        sumReg      <= '0;
                        overflowReg <= 1'b0;
                        busyReg     <= 1'b1;
                        regnumReg   <= BASE_IDX;
                    end
                end

                READ: begin
                    sumReg      <= addResult;
                    overflowReg <= overflowReg | addCarry;
                    if (idxReg < LAST_INDEX) begin
                        idxReg    <= idxNext;
                        regnumReg <= regnumStep;
                    end else begin
                        stateReg  <= DONE;
                        busyReg   <= 1'b0;
                        doneReg   <= 1'b1;
                        regnumReg <= 5'd0;
                    end
                end

                DONE: begin
                    if (go) begin
                        stateReg  <= ARMED;
                        doneReg   <= 1'b0;
                        regnumReg <= BASE_IDX;
                    end
                end

                default: begin
                    stateReg  <= IDLE;
                    busyReg   <= 1'b0;
                    doneReg   <= 1'b0;
                    regnumReg <= 5'd0;
                end
            endcase
        end
    end

    assign regnum   = regnumReg;
    assign busy     = busyReg;
    assign done     = doneReg;
    assign sum      = sumReg;
    assign overflow = overflowReg;

endmodule

// File: tb/tb_reg_reader.sv
// Directed bench for reg_reader: a behavioural register file answers reads, and a queue of
// expected read indices plus a reference sum/carry model check every run.
module tb_reg_reader;

    localparam int WIDTH = 32;
    localparam int BASE  = 8;
    localparam int COUNT = 4;

    logic             clock;
    logic             reset;
    logic             go;
    logic             direction;
    logic [WIDTH-1:0] rdata;
    logic [4:0]       regnum;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             overflow;

    logic [WIDTH-1:0] regFile [32];
    logic [4:0]       expQ [$];

    int               assertCount = 0;
    int               failCount   = 0;
    logic [WIDTH-1:0] prevSum     = '0;
    logic             prevOv      = 1'b0;

    reg_reader #(.WIDTH(WIDTH), .BASE(BASE), .COUNT(COUNT)) dut (
        .clock     (clock),
        .reset     (reset),
        .go        (go),
        .direction (direction),
        .rdata     (rdata),
        .regnum    (regnum),
        .busy      (busy),
        .done      (done),
        .sum       (sum),
        .overflow  (overflow)
    );

    assign rdata = regFile[regnum];

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        assert (observed === expected)
        else begin
            failCount++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // One complete arm/launch/read/done cycle. disturb wiggles go and direction during READ.
    task automatic doRun(input string name, input bit d, input bit disturb);
        logic [WIDTH:0]   acc;
        logic [WIDTH-1:0] expSum;
        logic             expOv;
        int               cycles;
        int               ridx;

        go = 1'b1;
        direction = d;
        repeat (3) tick;
        check({name, ".armRegnum"}, 32'(regnum), 32'(BASE));
        check({name, ".armBusy"}, 32'(busy), 32'd0);
        check({name, ".armDone"}, 32'(done), 32'd0);
        check({name, ".armSumHeld"}, sum, prevSum);
        check({name, ".armOvHeld"}, 32'(overflow), 32'(prevOv));

        go = 1'b0;
        expSum = '0;
        expOv  = 1'b0;
        for (int i = 0; i <= COUNT; i++) begin
            ridx = d ? BASE + i : BASE - i;
            expQ.push_back(5'(ridx));
            acc    = {1'b0, expSum} + {1'b0, regFile[ridx]};
            expSum = acc[WIDTH-1:0];
            expOv  = expOv | acc[WIDTH];
        end

        tick;
        cycles = 0;
        while (busy === 1'b1 && cycles < 20) begin
            if (expQ.size() == 0)
                check({name, ".readExtraCycle"}, 32'(busy), 32'd0);
            else
                check({name, ".readRegnum"}, 32'(regnum), 32'(expQ.pop_front()));
            if (disturb) begin
                direction = ~direction;
                go = (cycles == 1 || cycles == 2);
            end
            tick;
            cycles++;
        end
        go = 1'b0;
        direction = d;

        check({name, ".busyCycles"}, 32'(cycles), 32'(COUNT + 1));
        check({name, ".queueDrained"}, 32'(expQ.size()), 32'd0);
        expQ.delete();
        check({name, ".done"}, 32'(done), 32'd1);
        check({name, ".busyOff"}, 32'(busy), 32'd0);
        check({name, ".doneRegnum"}, 32'(regnum), 32'd0);
        check({name, ".sum"}, sum, expSum);
        check({name, ".overflow"}, 32'(overflow), 32'(expOv));

        tick;
        check({name, ".doneHeld"}, 32'(done), 32'd1);
        check({name, ".sumHeld"}, sum, expSum);
        check({name, ".ovHeld"}, 32'(overflow), 32'(expOv));

        prevSum = expSum;
        prevOv  = expOv;
        $display("run %s dir=%0d cycles=%0d sum=0x%08h overflow=%0d", name, d, cycles, sum, overflow);
    endtask

    initial begin
        for (int i = 0; i < 32; i++) regFile[i] = 32'(i * 32'h0101_0000);
        reset = 1'b0;
        go = 1'b0;
        direction = 1'b0;
        repeat (2) tick;
        check("reset.regnum", 32'(regnum), 32'd0);
        check("reset.busy", 32'(busy), 32'd0);
        check("reset.done", 32'(done), 32'd0);
        check("reset.sum", sum, 32'd0);
        check("reset.overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        tick;
        check("idle.regnum", 32'(regnum), 32'd0);

        // Ascending 1..5, then the same run with go/direction disturbed during READ.
        for (int i = 0; i <= COUNT; i++) regFile[BASE + i] = 32'(i + 1);
        doRun("asc", 1'b1, 1'b0);
        doRun("ignoredInputs", 1'b1, 1'b1);

        // Descending 0x10..0x50 from register 8 down to 4.
        for (int i = 0; i <= COUNT; i++) regFile[BASE - i] = 32'((i + 1) * 16);
        doRun("desc", 1'b0, 1'b0);

        // All-ones block: four carries, sum wraps to 0xFFFFFFFB.
        for (int i = BASE - COUNT; i <= BASE + COUNT; i++) regFile[i] = 32'hFFFF_FFFF;
        doRun("overflow", 1'b1, 1'b0);
        check("overflow.sumValue", sum, 32'hFFFF_FFFB);

        // Rerun from DONE: prior sum/overflow held through ARMED, cleared at launch.
        for (int i = 0; i <= COUNT; i++) regFile[BASE - i] = 32'((i + 1) * 16);
        doRun("rerunDesc", 1'b0, 1'b0);
        check("rerun.sumValue", sum, 32'h0000_00F0);
        check("rerun.ovCleared", 32'(overflow), 32'd0);

        // Reset in the middle of READ at idx 2; go held high during reset must not arm.
        go = 1'b1;
        direction = 1'b1;
        repeat (2) tick;
        go = 1'b0;
        tick;
        repeat (2) tick;
        check("midReset.preRegnum", 32'(regnum), 32'(BASE + 2));
        check("midReset.preBusy", 32'(busy), 32'd1);
        reset = 1'b0;
        go = 1'b1;
        tick;
        check("midReset.regnum", 32'(regnum), 32'd0);
        check("midReset.sum", sum, 32'd0);
        check("midReset.busy", 32'(busy), 32'd0);
        check("midReset.done", 32'(done), 32'd0);
        check("midReset.overflow", 32'(overflow), 32'd0);
        reset = 1'b1;
        go = 1'b0;
        repeat (4) tick;
        check("afterReset.regnum", 32'(regnum), 32'd0);
        check("afterReset.busy", 32'(busy), 32'd0);
        check("afterReset.done", 32'(done), 32'd0);
        $display("run midReset regnum=%0d busy=%0d done=%0d sum=0x%08h", regnum, busy, done, sum);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
